// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: edge-detects 13 key levels into pending press and
// release queues, then services one event per clock onto VOICES voices.
module voice_allocator #(
  parameter int VOICES = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [12:0]         keys,
  input  logic [2:0]          octave,
  output logic [4*VOICES-1:0] voice_note,
  output logic [3*VOICES-1:0] voice_octave,
  output logic [VOICES-1:0]   voice_active,
  output logic [VOICES-1:0]   voice_trigger,
  output logic                steal,
  output logic                busy
);
  logic [12:0]            r_k_q, r_pend_p, r_pend_r;
  logic [VOICES-1:0][3:0] r_note;
  logic [VOICES-1:0][2:0] r_oct, r_age;
  logic [VOICES-1:0]      r_active, r_trig;
  logic                   r_steal;

  logic [12:0]       w_rise, w_fall, w_svc_r, w_svc_p, w_svc;
  logic              w_do_r, w_do_p, w_rel_hit, w_full;
  logic [3:0]        w_key, w_cnt, w_rank;
  logic [2:0]        w_rel_age;
  logic [VOICES-1:0] w_rel_oh, w_free_oh, w_old_oh, w_tgt_oh;

  // Releases win over presses; each queue is serviced lowest key first.
  always_comb begin
    w_rise  = keys & ~r_k_q;
    w_fall  = ~keys & r_k_q;
    w_do_r  = |r_pend_r;
    w_do_p  = ~w_do_r & (|r_pend_p);
    w_svc_r = r_pend_r & (~r_pend_r + 13'd1);
    w_svc_p = w_do_r ? 13'd0 : (r_pend_p & (~r_pend_p + 13'd1));
    w_svc   = w_svc_r | w_svc_p;
    w_key   = 4'd0;
    for (int k = 0; k < 13; k++)
      if (w_svc[k]) w_key = 4'(k);
  end

  // Ages of active voices are a permutation of 0..N-1, so the oldest voice
  // of a full bank is the unique one at age VOICES-1.
  always_comb begin
    w_rel_oh  = '0;
    w_old_oh  = '0;
    w_rel_age = 3'd0;
    w_cnt     = 4'd0;
    for (int v = 0; v < VOICES; v++) begin
      w_rel_oh[v] = r_active[v] && (r_note[v] == w_key);
      w_old_oh[v] = r_active[v] && (r_age[v] == 3'(VOICES-1));
      if (w_rel_oh[v]) w_rel_age = w_rel_age | r_age[v];
      w_cnt = w_cnt + {3'd0, r_active[v]};
    end
    w_rel_hit = |w_rel_oh;
    w_free_oh = ~r_active & (r_active + VOICES'(1));
    w_full    = (w_cnt == 4'(VOICES));
    w_tgt_oh  = w_full ? w_old_oh : w_free_oh;
    w_rank    = w_full ? 4'(VOICES-1) : w_cnt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_k_q    <= '0;
      r_pend_p <= '0;
      r_pend_r <= '0;
      r_note   <= {VOICES{4'hF}};
      r_oct    <= '0;
      r_age    <= '0;
      r_active <= '0;
      r_trig   <= '0;
      r_steal  <= 1'b0;
    end else begin
      r_k_q    <= keys;
      r_pend_p <= (r_pend_p | w_rise) & ~w_fall & ~w_svc_p;
      // A fall on a still-pending press only cancels that press.
      r_pend_r <= (r_pend_r | (w_fall & ~r_pend_p)) & ~w_svc_r;
      r_trig   <= '0;
      r_steal  <= w_do_p & w_full;
      for (int v = 0; v < VOICES; v++) begin
        if (w_do_r && w_rel_hit) begin
          if (w_rel_oh[v]) begin
            r_active[v] <= 1'b0;
            r_note[v]   <= 4'hF;
            r_age[v]    <= 3'd0;
          end else if (r_active[v] && (r_age[v] > w_rel_age)) begin
            r_age[v] <= r_age[v] - 3'd1;
          end
        end else if (w_do_p) begin
          if (w_tgt_oh[v]) begin
            r_note[v]   <= w_key;
            r_oct[v]    <= octave;
            r_age[v]    <= 3'd0;
            r_active[v] <= 1'b1;
            r_trig[v]   <= 1'b1;
          end else if (r_active[v] && ({1'b0, r_age[v]} < w_rank)) begin
            r_age[v] <= r_age[v] + 3'd1;
          end
        end
      end
    end
  end

  assign voice_note    = r_note;
  assign voice_octave  = r_oct;
  assign voice_active  = r_active;
  assign voice_trigger = r_trig;
  assign steal         = r_steal;
  assign busy          = (|r_pend_p) | (|r_pend_r);
endmodule

// File: tb/tb_voice_allocator.sv
// Directed scoreboard bench for voice_allocator (VOICES=4): stimulus pushes
// expected voice events, a negedge monitor pops and compares them.
module tb_voice_allocator;
  logic        clk, resetn;
  logic [12:0] keys;
  logic [2:0]  octave;
  logic [15:0] voice_note;
  logic [11:0] voice_octave;
  logic [3:0]  voice_active, voice_trigger;
  logic        steal, busy;

  voice_allocator #(.VOICES(4)) dut (
    .clk(clk), .resetn(resetn), .keys(keys), .octave(octave),
    .voice_note(voice_note), .voice_octave(voice_octave),
    .voice_active(voice_active), .voice_trigger(voice_trigger),
    .steal(steal), .busy(busy)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_exp, mon_got;
  logic [15:0] prev_note;
  logic [3:0]  prev_act;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [36:0] ev(input logic [15:0] n, input logic [11:0] o,
                                     input logic [3:0] a, input logic [3:0] t,
                                     input logic s);
    return {n, o, a, t, s};
  endfunction

  // An event is any change of notes/active, or any trigger/steal pulse.
  always @(negedge clk) begin
    if (resetn && ((voice_note != prev_note) || (voice_active != prev_act) ||
                   (|voice_trigger) || steal)) begin
      mon_got = {voice_note, voice_octave, voice_active, voice_trigger, steal};
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event: got=%h expected=none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("voice_event", 64'(mon_got), 64'(mon_exp));
      end
    end
    prev_note = voice_note;
    prev_act  = voice_active;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    keys   = '0;
    octave = '0;
    step(2);
    resetn = 1'b1;
    step(1);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 60) begin
      step(1);
      c++;
    end
    chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    step(2);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic press(input int k, input logic [15:0] n, input logic [3:0] a,
                       input logic [3:0] t, input logic s);
    keys[k] = 1'b1;
    exp_q.push_back(ev(n, 12'h000, a, t, s));
    step(1);
  endtask

  initial begin
    resetn = 1'b0;
    keys   = '0;
    octave = '0;
    step(2);
    chk("rst_note", 64'(voice_note), 64'hFFFF);
    chk("rst_active", 64'(voice_active), 64'h0);
    chk("rst_octave", 64'(voice_octave), 64'h0);
    chk("rst_trig_steal", 64'({voice_trigger, steal}), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    resetn = 1'b1;
    step(1);

    // Reset asserted while the queue of three presses is mid-service.
    keys = 13'h0007;
    exp_q.push_back(ev(16'hFFF0, 12'h000, 4'h1, 4'h1, 1'b0));
    step(1);
    chk("midrst_busy_e1", 64'(busy), 64'd1);
    step(1);
    resetn = 1'b0;
    #1;
    chk("midrst_note", 64'(voice_note), 64'hFFFF);
    chk("midrst_active", 64'(voice_active), 64'h0);
    chk("midrst_busy", 64'(busy), 64'h0);
    exp_q.push_back(ev(16'hFFF0, 12'h000, 4'h1, 4'h1, 1'b0));
    exp_q.push_back(ev(16'hFF10, 12'h000, 4'h3, 4'h2, 1'b0));
    exp_q.push_back(ev(16'hF210, 12'h000, 4'h7, 4'h4, 1'b0));
    step(1);
    resetn = 1'b1;
    drain();
    keys = 13'h0000;
    exp_q.push_back(ev(16'hF21F, 12'h000, 4'h6, 4'h0, 1'b0));
    exp_q.push_back(ev(16'hF2FF, 12'h000, 4'h4, 4'h0, 1'b0));
    exp_q.push_back(ev(16'hFFFF, 12'h000, 4'h0, 4'h0, 1'b0));
    drain();

    // Single press with octave 1, then release; two-edge latency each way.
    do_reset();
    octave = 3'd1;
    keys = 13'h0200;
    exp_q.push_back(ev(16'hFFF9, 12'h001, 4'h1, 4'h1, 1'b0));
    step(1);
    chk("single_busy_e1", 64'(busy), 64'd1);
    chk("single_active_e1", 64'(voice_active), 64'h0);
    step(1);
    chk("single_trig_e2", 64'(voice_trigger), 64'h1);
    chk("single_busy_e2", 64'(busy), 64'd0);
    step(1);
    chk("single_trig_pulse", 64'(voice_trigger), 64'h0);
    keys = 13'h0000;
    exp_q.push_back(ev(16'hFFFF, 12'h001, 4'h0, 4'h0, 1'b0));
    step(1);
    chk("single_rel_busy", 64'(busy), 64'd1);
    step(1);
    chk("single_rel_active", 64'(voice_active), 64'h0);
    drain();

    // Fill all voices, steal the oldest, then a release of the stolen key is dropped.
    do_reset();
    press(0, 16'hFFF0, 4'h1, 4'h1, 1'b0);
    press(2, 16'hFF20, 4'h3, 4'h2, 1'b0);
    press(4, 16'hF420, 4'h7, 4'h4, 1'b0);
    press(5, 16'h5420, 4'hF, 4'h8, 1'b0);
    press(7, 16'h5427, 4'hF, 4'h1, 1'b1);
    drain();
    keys[0] = 1'b0;
    step(4);
    chk("stolen_rel_note", 64'(voice_note), 64'h5427);
    chk("stolen_rel_active", 64'(voice_active), 64'hF);
    drain();

    // Release of a middle-aged voice reorders ages before the next steal.
    do_reset();
    press(0, 16'hFFF0, 4'h1, 4'h1, 1'b0);
    press(2, 16'hFF20, 4'h3, 4'h2, 1'b0);
    press(4, 16'hF420, 4'h7, 4'h4, 1'b0);
    press(5, 16'h5420, 4'hF, 4'h8, 1'b0);
    drain();
    keys[2] = 1'b0;
    exp_q.push_back(ev(16'h54F0, 12'h000, 4'hD, 4'h0, 1'b0));
    step(3);
    press(7, 16'h5470, 4'hF, 4'h2, 1'b0);
    press(9, 16'h5479, 4'hF, 4'h1, 1'b1);
    drain();

    // Same-cycle release and press: release first, busy for exactly 2 cycles.
    do_reset();
    keys = 13'h0003;
    exp_q.push_back(ev(16'hFFF0, 12'h000, 4'h1, 4'h1, 1'b0));
    exp_q.push_back(ev(16'hFF10, 12'h000, 4'h3, 4'h2, 1'b0));
    drain();
    keys = 13'h0012;
    exp_q.push_back(ev(16'hFF1F, 12'h000, 4'h2, 4'h0, 1'b0));
    exp_q.push_back(ev(16'hFF14, 12'h000, 4'h3, 4'h1, 1'b0));
    step(1);
    chk("simul_busy_c1", 64'(busy), 64'd1);
    step(1);
    chk("simul_busy_c2", 64'(busy), 64'd1);
    step(1);
    chk("simul_busy_c3", 64'(busy), 64'd0);
    drain();

    // Key 3 rises and falls while twelve presses are queued: it never sounds.
    do_reset();
    keys = 13'h1FF7;
    exp_q.push_back(ev(16'hFFF0, 12'h000, 4'h1, 4'h1, 1'b0));
    exp_q.push_back(ev(16'hFF10, 12'h000, 4'h3, 4'h2, 1'b0));
    exp_q.push_back(ev(16'hF210, 12'h000, 4'h7, 4'h4, 1'b0));
    exp_q.push_back(ev(16'h4210, 12'h000, 4'hF, 4'h8, 1'b0));
    exp_q.push_back(ev(16'h4215, 12'h000, 4'hF, 4'h1, 1'b1));
    exp_q.push_back(ev(16'h4265, 12'h000, 4'hF, 4'h2, 1'b1));
    exp_q.push_back(ev(16'h4765, 12'h000, 4'hF, 4'h4, 1'b1));
    exp_q.push_back(ev(16'h8765, 12'h000, 4'hF, 4'h8, 1'b1));
    exp_q.push_back(ev(16'h8769, 12'h000, 4'hF, 4'h1, 1'b1));
    exp_q.push_back(ev(16'h87A9, 12'h000, 4'hF, 4'h2, 1'b1));
    exp_q.push_back(ev(16'h8BA9, 12'h000, 4'hF, 4'h4, 1'b1));
    exp_q.push_back(ev(16'hCBA9, 12'h000, 4'hF, 4'h8, 1'b1));
    step(1);
    keys = 13'h1FFF;
    step(1);
    keys = 13'h1FF7;
    drain();
    keys = 13'h0000;
    exp_q.push_back(ev(16'hCBAF, 12'h000, 4'hE, 4'h0, 1'b0));
    exp_q.push_back(ev(16'hCBFF, 12'h000, 4'hC, 4'h0, 1'b0));
    exp_q.push_back(ev(16'hCFFF, 12'h000, 4'h8, 4'h0, 1'b0));
    exp_q.push_back(ev(16'hFFFF, 12'h000, 4'h0, 4'h0, 1'b0));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice allocator that sits between the debounced keyboard key bank and the per-voice note-to-frequency lookups. It turns 13 key levels into press/release events and assigns each pressed key to one of VOICES synthesis voices. When all voices are busy it steals the least-recently-allocated voice. Each voice's note/octave output drives its own lookup instance; note code 15 means silence.

## Interface
- VOICES, 4, number of voices; legal range 2..8.
- clk  input  1  system clock.
- resetn  input  1  reset; asynchronous, active-low.
- keys  input  13  key levels, bit k = note k (0 = C … 12 = upper C); synchronous to clk, already debounced.
- octave  input  3  octave select, sampled per voice at allocation.
- voice_note  output  4*VOICES  note code of voice v in bits [4v+3:4v]; 15 when inactive.
- voice_octave  output  3*VOICES  octave of voice v in bits [3v+2:3v].
- voice_active  output  VOICES  voice v holds a key.
- voice_trigger  output  VOICES  one-cycle pulse when voice v is (re)assigned.
- steal  output  1  one-cycle pulse when an assignment stole an active voice.
- busy  output  1  pending press or release mask non-zero.

## Operation
- Edge detect: k_q <= keys every cycle. rise = keys & ~k_q; fall = ~keys & k_q.
- Pending masks (13 bits each):
  - pend_p <= (pend_p | rise) & ~fall & ~svc_p.
  - pend_r <= (pend_r | (fall & ~pend_p)) & ~svc_r.
  - A release of a key whose press is still pending cancels the press and generates no release.
- Service: one event per cycle, from the registered masks.
  - Releases have priority. svc_r = lowest set bit of pend_r; otherwise svc_p = lowest set bit of pend_p.
- Release of key k:
  - Find the active voice with note == k.
  - Clear its active bit, set its note to 15, and decrement the age of every active voice whose age exceeds the released voice's age.
  - If no voice matches (the key was stolen), drop the event with no output change.
- Press of key k, with N = number of active voices:
  - If N < VOICES, the target is the lowest-indexed inactive voice and R = N.
  - Otherwise the target is the voice with age VOICES-1, R = VOICES-1, and steal pulses.
  - Every other active voice with age < R increments its age.
  - The target gets note = k, octave = octave input in that cycle, age = 0, and active = 1; its voice_trigger bit pulses.
- Age invariant: active voices always hold distinct ages 0..N-1. Inactive voice age is don't-care and held at 0.
- Changing octave never retargets voices already sounding.

## Timing
- Reset (asynchronous, any time, including mid-service):
  - k_q = 0; pend_p = pend_r = 0; voice_active = 0; voice_note = all 15; voice_octave = 0; ages = 0.
  - voice_trigger = 0, steal = 0, busy = 0.
  - Keys already held when resetn deasserts appear as rises on the first clock edge.
- Latency: keys changes before edge E0 → pending set at E1 → voice outputs, trigger and steal update at E2 when no other events are queued. Each queued event adds one cycle.
- Throughput: one event per clock. 13 simultaneous presses drain in 13 cycles. busy is high from E1 until the edge after the last service.
- voice_trigger and steal are registered and high exactly one cycle, coincident with the new voice_note.
- Same-cycle press of key a and release of key b: both are queued; the release is serviced first.
- Pressing a key that is already held is impossible by edge detection; no duplicate voices arise.

## Test plan
- Reset mid-operation: VOICES=4, keys=0x0007, assert resetn low for one cycle during service → all voice_note=15, active=0, busy=0. After release, the three rises re-queue and voices 0,1,2 get notes 0,1,2.
- Single press: octave=1, keys bit 9 rises at E0 → at E2 voice 0 note=9, octave=1, active=0001, trigger=0001 for one cycle. Drop bit 9 → two edges later voice 0 note=15, active=0000.
- Fill and steal: press keys 0,2,4,5 on separate cycles, then key 7 → voice 0 (key 0, oldest) becomes note 7, steal=1, trigger=0001. A later release of key 0 produces no change.
- Release reorders age: with keys 0,2,4,5 held, release key 2 (voice 1), press 7 then 9 → 7 goes to voice 1 without steal; 9 steals voice 0 (key 0).
- Simultaneous edges: keys 0x0003 held, then in one cycle bit 0 falls and bit 4 rises → first serviced cycle frees voice 0, next cycle assigns key 4 to voice 0; busy high for exactly 2 cycles.
- Cancelled press: bit 3 rises while 12 other presses are queued and falls before service → key 3 never appears on any voice, and no release is serviced for it.
